quant_rle_pack: RTL and testbench

// Post-quantisation stage directly downstream of the pipelined unsigned long-division quantiser.
// Re-attaches the coefficient sign, which is carried alongside the divider in a latency-matched sideband.

---
 rtl/quant_rle_pack.sv | 75 +++++++
 tb/tb_quant_rle_pack.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quant_rle_pack.sv
// quant_rle_pack: re-signs divider quotients, predicts DC and packs each zig-zag block into run-length symbols
module quant_rle_pack #(
  parameter int STEPS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in_valid,
  input  logic             div_in_sign,
  input  logic [STEPS-1:0] q_data,
  input  logic             q_valid,
  input  logic             frame_start,
  output logic             sym_valid,
  output logic             sym_dc,
  output logic             sym_eob,
  output logic [1:0]       sym_zrl,
  output logic [3:0]       sym_run,
  output logic [STEPS+1:0] sym_val,
  output logic             blk_done,
  output logic             err_align
);
  localparam int VW = STEPS + 2;
  logic [STEPS-1:0] sb_v, sb_s;
  logic [5:0] k, run, kk, run_e;
  logic signed [STEPS:0] pred, pred_e, c;
  logic [VW-1:0] dc_diff;
  logic nz, ac, emit;
  // frame_start acts on the coefficient arriving in the same cycle
  always_comb begin
    kk = frame_start ? 6'd0 : k;
    run_e = frame_start ? 6'd0 : run;
    pred_e = frame_start ? '0 : pred;
    c = sb_s[STEPS-1] ? -$signed({1'b0, q_data}) : $signed({1'b0, q_data});
    nz = |q_data;
    dc_diff = {c[STEPS], c} - {pred_e[STEPS], pred_e};
    ac = kk != 6'd0 && nz;
    emit = q_valid && (kk == 6'd0 || nz || kk == 6'd63);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v <= '0;
      sb_s <= '0;
      k <= '0;
      run <= '0;
      pred <= '0;
      sym_valid <= 1'b0;
      sym_dc <= 1'b0;
      sym_eob <= 1'b0;
      sym_zrl <= '0;
      sym_run <= '0;
      sym_val <= '0;
      blk_done <= 1'b0;
      err_align <= 1'b0;
    end else begin
      sb_v <= {sb_v[STEPS-2:0], div_in_valid};
      sb_s <= {sb_s[STEPS-2:0], div_in_sign};
      if (sb_v[STEPS-1] != q_valid) err_align <= 1'b1;
      sym_valid <= emit;
      sym_dc <= q_valid && kk == 6'd0;
      sym_eob <= q_valid && kk == 6'd63 && !nz;
      sym_zrl <= (q_valid && ac) ? run_e[5:4] : 2'd0;
      sym_run <= (q_valid && ac) ? run_e[3:0] : 4'd0;
      sym_val <= !q_valid ? '0 : kk == 6'd0 ? dc_diff : nz ? {c[STEPS], c} : '0;
      blk_done <= q_valid && kk == 6'd63;
      if (q_valid) begin
        k <= kk + 6'd1;
        run <= emit ? 6'd0 : run_e + 6'd1;
        if (kk == 6'd0) pred <= c;
      end else if (frame_start) begin
        k <= '0;
        run <= '0;
        pred <= '0;
      end
    end
  end
endmodule

// File: tb/tb_quant_rle_pack.sv
// tb_quant_rle_pack: divider-latency stimulus with a scoreboard of expected symbols
module tb_quant_rle_pack;
  localparam int STEPS = 8;
  localparam int VW = STEPS + 2;
  logic clk = 1'b0;
  logic rst, div_in_valid, div_in_sign, q_valid, frame_start;
  logic [STEPS-1:0] q_data;
  logic sym_valid, sym_dc, sym_eob, blk_done, err_align;
  logic [1:0] sym_zrl;
  logic [3:0] sym_run;
  logic [VW-1:0] sym_val;

  quant_rle_pack #(.STEPS(STEPS)) dut (
    .clk(clk), .rst(rst), .div_in_valid(div_in_valid), .div_in_sign(div_in_sign),
    .q_data(q_data), .q_valid(q_valid), .frame_start(frame_start),
    .sym_valid(sym_valid), .sym_dc(sym_dc), .sym_eob(sym_eob), .sym_zrl(sym_zrl),
    .sym_run(sym_run), .sym_val(sym_val), .blk_done(blk_done), .err_align(err_align)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    logic dc, eob, done;
    logic [1:0] zrl;
    logic [3:0] run;
    logic signed [VW-1:0] val;
  } sym_t;

  sym_t exp_q[$];
  int checks = 0, failures = 0, cyc = 0, nsym = 0;
  logic mon_en = 1'b0, force_q = 1'b0;
  logic pv[STEPS];
  logic ps[STEPS];
  logic [STEPS-1:0] pm[STEPS];
  int mk, mrun, mpred;
  logic signed [VW-1:0] last_val, last_dc;
  logic [1:0] last_zrl;
  logic [3:0] last_run;
  logic last_done;

  // reference behaviour applied when a quotient reaches the DUT
  task automatic model(input logic s, input logic [STEPS-1:0] m, input logic fs);
    sym_t e;
    int c;
    logic emit;
    if (fs) begin mk = 0; mrun = 0; mpred = 0; end
    c = s ? -int'(m) : int'(m);
    e.cyc = cyc + 1; e.dc = 0; e.eob = 0; e.zrl = 0; e.run = 0; e.val = 0;
    e.done = (mk == 63);
    emit = 1'b1;
    if (mk == 0) begin
      e.dc = 1; e.val = VW'(c - mpred); mpred = c; mrun = 0;
    end else if (c != 0) begin
      e.zrl = 2'(mrun / 16); e.run = 4'(mrun % 16); e.val = VW'(c); mrun = 0;
    end else if (mk == 63) begin
      e.eob = 1; mrun = 0;
    end else begin
      mrun++; emit = 1'b0;
    end
    mk = (mk + 1) % 64;
    if (emit) exp_q.push_back(e);
  endtask

  // one clock: divider model of latency STEPS feeds q_* from the div_in_* history
  task automatic tick(input logic dv, input logic ds, input int mag, input logic fs);
    div_in_valid = dv; div_in_sign = ds; frame_start = fs;
    q_valid = pv[STEPS-1] | force_q; q_data = pm[STEPS-1];
    if (q_valid && !rst) model(ps[STEPS-1], q_data, fs);
    else if (fs) begin mk = 0; mrun = 0; mpred = 0; end
    for (int i = STEPS - 1; i > 0; i--) begin pv[i] = pv[i-1]; ps[i] = ps[i-1]; pm[i] = pm[i-1]; end
    pv[0] = dv; ps[0] = ds; pm[0] = STEPS'(mag);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic send(input int v);
    tick(1'b1, v < 0, v < 0 ? -v : v, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic fstart();
    tick(1'b0, 1'b0, 0, 1'b1);
  endtask

  task automatic dc_block(input int dc);
    send(dc);
    repeat (63) send(0);
    idle(STEPS + 2);
  endtask

  task automatic do_reset();
    rst = 1'b1; force_q = 1'b0;
    for (int i = 0; i < STEPS; i++) begin pv[i] = 0; ps[i] = 0; pm[i] = '0; end
    tick(1'b0, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b0);
    rst = 1'b0; mk = 0; mrun = 0; mpred = 0;
  endtask

  always @(negedge clk) begin
    sym_t e;
    if (mon_en) begin
      checks++;
      if (sym_valid) begin
        nsym++;
        last_val = sym_val; last_zrl = sym_zrl; last_run = sym_run; last_done = blk_done;
        if (sym_dc) last_dc = sym_val;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sym_unexpected: cyc=%0d dc=%b eob=%b val=%0d, none expected", cyc, sym_dc, sym_eob, $signed(sym_val));
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.cyc || sym_dc !== e.dc || sym_eob !== e.eob || sym_zrl !== e.zrl ||
              sym_run !== e.run || sym_val !== e.val || blk_done !== e.done) begin
            failures++;
            $display("FAIL sym: got cyc=%0d dc=%b eob=%b zrl=%0d run=%0d val=%0d done=%b, want cyc=%0d dc=%b eob=%b zrl=%0d run=%0d val=%0d done=%b",
                     cyc, sym_dc, sym_eob, sym_zrl, sym_run, $signed(sym_val), blk_done,
                     e.cyc, e.dc, e.eob, e.zrl, e.run, e.val, e.done);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        failures++;
        $display("FAIL sym_missing: cyc=%0d no symbol, want one due cyc=%0d val=%0d", cyc, e.cyc, e.val);
      end else if ({sym_dc, sym_eob, sym_zrl, sym_run, sym_val, blk_done} !== '0) begin
        failures++;
        $display("FAIL idle_zero: cyc=%0d sym fields=%h, want 0", cyc, {sym_dc, sym_eob, sym_zrl, sym_run, sym_val, blk_done});
      end
    end
  end

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    checks++; if (sym_valid !== 1'b0) begin failures++; $display("FAIL reset_sym_valid: got %b want 0", sym_valid); end
    checks++; if (sym_val !== '0) begin failures++; $display("FAIL reset_sym_val: got %h want 0", sym_val); end
    checks++; if (blk_done !== 1'b0) begin failures++; $display("FAIL reset_blk_done: got %b want 0", blk_done); end
    checks++; if (err_align !== 1'b0) begin failures++; $display("FAIL reset_err_align: got %b want 0", err_align); end
  endtask

  task automatic test_sign_latency();
    int n, n0;
    n0 = nsym;
    send(-5);
    n = 1;
    while (!sym_valid && n < 3 * STEPS) begin idle(1); n++; end
    checks++; if (n != STEPS + 1) begin failures++; $display("FAIL latency: got %0d cycles want %0d", n, STEPS + 1); end
    checks++; if (sym_dc !== 1'b1 || $signed(sym_val) != -5) begin failures++; $display("FAIL sign_dc: got dc=%b val=%0d want dc=1 val=-5", sym_dc, $signed(sym_val)); end
    repeat (63) send(0);
    idle(STEPS + 2);
    checks++; if (nsym - n0 != 2) begin failures++; $display("FAIL sign_block_count: got %0d want 2", nsym - n0); end
  endtask

  task automatic test_block();
    int n0;
    fstart();
    n0 = nsym;
    for (int i = 0; i < 64; i++) send(i == 0 ? 10 : i == 1 ? 3 : i == 20 ? -2 : 0);
    idle(STEPS + 2);
    checks++; if (nsym - n0 != 4) begin failures++; $display("FAIL block_count: got %0d want 4", nsym - n0); end
    checks++; if (last_dc != 10) begin failures++; $display("FAIL block_dc: got %0d want 10", last_dc); end
    checks++; if (last_done !== 1'b1) begin failures++; $display("FAIL block_done: got %b want 1", last_done); end
  endtask

  task automatic test_tail();
    int n0;
    n0 = nsym;
    for (int i = 0; i < 64; i++) send(i == 63 ? 1 : 0);
    idle(STEPS + 2);
    checks++; if (nsym - n0 != 2) begin failures++; $display("FAIL tail_count: got %0d want 2", nsym - n0); end
    checks++; if (last_zrl !== 2'd3 || last_run !== 4'd14 || last_val != 1 || last_done !== 1'b1) begin
      failures++; $display("FAIL tail_sym: got zrl=%0d run=%0d val=%0d done=%b want 3 14 1 1", last_zrl, last_run, last_val, last_done);
    end
  endtask

  task automatic test_dc_predict();
    fstart();
    dc_block(10);
    checks++; if (last_dc != 10) begin failures++; $display("FAIL pred_first: got %0d want 10", last_dc); end
    dc_block(7);
    checks++; if (last_dc != -3) begin failures++; $display("FAIL pred_diff: got %0d want -3", last_dc); end
    fstart();
    dc_block(7);
    checks++; if (last_dc != 7) begin failures++; $display("FAIL pred_frame: got %0d want 7", last_dc); end
    dc_block(-255);
    checks++; if (last_dc != -262) begin failures++; $display("FAIL pred_neg: got %0d want -262", last_dc); end
    fstart();
    dc_block(-255);
    dc_block(255);
    checks++; if (last_dc != 510) begin failures++; $display("FAIL pred_max: got %0d want 510", last_dc); end
  endtask

  task automatic test_neg_zero();
    int n0;
    n0 = nsym;
    send(0);
    tick(1'b1, 1'b1, 0, 1'b0);
    send(4);
    idle(STEPS + 2);
    checks++; if (nsym - n0 != 2) begin failures++; $display("FAIL negzero_count: got %0d want 2", nsym - n0); end
    checks++; if (last_run !== 4'd1 || last_val != 4) begin failures++; $display("FAIL negzero_run: got run=%0d val=%0d want 1 4", last_run, last_val); end
    repeat (61) send(0);
    idle(STEPS + 2);
  endtask

  task automatic test_back_to_back();
    int m;
    for (int i = 0; i < 128; i++) begin
      m = int'($urandom_range(1, 255));
      send($urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) == 1 ? -m : m) : 0);
    end
    idle(STEPS + 2);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_faults();
    fstart();
    send(9);
    for (int i = 1; i < 30; i++) send(i % 5 == 0 ? -i : 0);
    idle(STEPS + 2);
    checks++; if (err_align !== 1'b0) begin failures++; $display("FAIL align_clean: got %b want 0", err_align); end
    do_reset();
    dc_block(6);
    checks++; if (last_dc != 6) begin failures++; $display("FAIL reset_pred: got %0d want 6", last_dc); end
    force_q = 1'b1;
    idle(1);
    force_q = 1'b0;
    idle(2);
    checks++; if (err_align !== 1'b1) begin failures++; $display("FAIL align_set: got %b want 1", err_align); end
    idle(20);
    checks++; if (err_align !== 1'b1) begin failures++; $display("FAIL align_sticky: got %b want 1", err_align); end
  endtask

  initial begin
    test_reset();
    test_sign_latency();
    test_block();
    test_tail();
    test_dc_predict();
    test_neg_zero();
    test_back_to_back();
    test_faults();
    idle(4);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL final_pending: got %0d want 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
